// File: rtl/fifo_pdata_widen.sv
// Width-up FIFO: packs RATIO lanes of DW_IN bits into one word with per-lane
// keep flags, buffers DEPTH words, and reads them back with one cycle of latency.
module fifo_pdata_widen #(
    parameter int DW_IN   = 8,
    parameter int RATIO   = 4,
    parameter int DEPTH   = 256,
    parameter int REVERSE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DW_IN-1:0]         dw,
    input  logic                     wr_last,
    output logic                     wr_full,
    input  logic                     rd_en,
    output logic [DW_IN*RATIO-1:0]   qr,
    output logic [RATIO-1:0]         qr_keep,
    output logic                     qr_vld,
    output logic                     rd_empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic                     udf,
    input  logic                     clr_err
);
    localparam int AW  = $clog2(DEPTH);
    localparam int LCW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int OW  = DW_IN * RATIO;
    localparam int MW  = OW + RATIO;

    logic [LCW-1:0]                lc;
    logic [LCW-1:0]                lane;
    logic [RATIO-1:0][DW_IN-1:0]   pack_data;
    logic [RATIO-1:0][DW_IN-1:0]   word_data;
    logic [RATIO-1:0]              pack_keep;
    logic [RATIO-1:0]              word_keep;
    logic [AW-1:0]                 wp;
    logic [AW-1:0]                 rp;
    logic [MW-1:0]                 mem [DEPTH];
    logic                          wr_acc;
    logic                          push;
    logic                          pop;

    assign wr_full  = (level == (AW+1)'(DEPTH));
    assign rd_empty = (level == '0);
    assign wr_acc   = wr_en & ~wr_full;
    assign push     = wr_acc & ((lc == LCW'(RATIO-1)) | wr_last);
    assign pop      = rd_en & ~rd_empty;
    assign lane     = (REVERSE != 0) ? (LCW'(RATIO-1) - lc) : lc;

    // Word as it would be pushed this cycle: packer plus the incoming lane.
    always_comb begin
        word_data       = pack_data;
        word_keep       = pack_keep;
        word_data[lane] = dw;
        word_keep[lane] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lc        <= '0;
            pack_data <= '0;
            pack_keep <= '0;
        end else if (wr_acc) begin
            if (push) begin
                lc        <= '0;
                pack_data <= '0;
                pack_keep <= '0;
            end else begin
                lc        <= lc + 1'b1;
                pack_data <= word_data;
                pack_keep <= word_keep;
            end
        end
    end

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= {word_keep, word_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp      <= '0;
            rp      <= '0;
            level   <= '0;
            qr      <= '0;
            qr_keep <= '0;
            qr_vld  <= 1'b0;
        end else begin
            qr_vld <= pop;
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp             <= rp + 1'b1;
                {qr_keep, qr}  <= mem[rp];
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Setting an error flag wins over clearing it in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (wr_en & wr_full) begin
                ovf <= 1'b1;
            end else if (clr_err) begin
                ovf <= 1'b0;
            end
            if (rd_en & rd_empty) begin
                udf <= 1'b1;
            end else if (clr_err) begin
                udf <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_pdata_widen.sv
// Scoreboard bench: two FIFOs (normal and reversed lane order) share one stimulus
// stream; expected words are queued at write time and popped on every qr_vld.
module tb_fifo_pdata_widen;
    localparam int DW    = 8;
    localparam int RATIO = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, wr_en, wr_last, rd_en, clr_err;
    logic [7:0]  dw;

    logic [31:0] a_qr, b_qr;
    logic [3:0]  a_keep, b_keep, a_level, b_level;
    logic        a_full, a_vld, a_empty, a_ovf, a_udf;
    logic        b_full, b_vld, b_empty, b_ovf, b_udf;

    int          checks   = 0;
    int          failures = 0;
    logic [35:0] qa[$];
    logic [35:0] qb[$];
    logic [35:0] last_a = '0;

    always #5 clk = ~clk;

    fifo_pdata_widen #(.DW_IN(DW), .RATIO(RATIO), .DEPTH(DEPTH), .REVERSE(0)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .dw(dw), .wr_last(wr_last),
        .wr_full(a_full), .rd_en(rd_en), .qr(a_qr), .qr_keep(a_keep),
        .qr_vld(a_vld), .rd_empty(a_empty), .level(a_level), .ovf(a_ovf),
        .udf(a_udf), .clr_err(clr_err));

    fifo_pdata_widen #(.DW_IN(DW), .RATIO(RATIO), .DEPTH(DEPTH), .REVERSE(1)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .dw(dw), .wr_last(wr_last),
        .wr_full(b_full), .rd_en(rd_en), .qr(b_qr), .qr_keep(b_keep),
        .qr_vld(b_vld), .rd_empty(b_empty), .level(b_level), .ovf(b_ovf),
        .udf(b_udf), .clr_err(clr_err));

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reversed-lane expectation: lane k of the normal word moves to lane 3-k.
    function automatic logic [35:0] rev(input logic [35:0] e);
        logic [35:0] r;
        for (int k = 0; k < 4; k++) begin
            r[k*8 +: 8] = e[(3-k)*8 +: 8];
            r[32+k]     = e[32+3-k];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (a_vld) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_vld", {a_keep, a_qr}, '1);
            end else begin
                last_a = qa.pop_front();
                chk("a_word", {a_keep, a_qr}, last_a);
            end
        end
        if (b_vld) begin
            if (qb.size() == 0) chk("b_unexpected_vld", {b_keep, b_qr}, '1);
            else chk("b_word", {b_keep, b_qr}, qb.pop_front());
        end
    end

    task automatic exp_push(input logic [35:0] e);
        qa.push_back(e);
        qb.push_back(rev(e));
    endtask

    task automatic wr(input logic [7:0] d, input logic last, input logic rd);
        wr_en = 1'b1; dw = d; wr_last = last; rd_en = rd;
        @(negedge clk);
        wr_en = 1'b0; wr_last = 1'b0; rd_en = 1'b0;
    endtask

    task automatic word4(input logic [31:0] w, input logic rd);
        exp_push({4'hF, w});
        wr(w[7:0], 1'b0, 1'b0);
        wr(w[15:8], 1'b0, 1'b0);
        wr(w[23:16], 1'b0, 1'b0);
        wr(w[31:24], 1'b0, rd);
    endtask

    task automatic rd();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_qr"},    {a_keep, a_qr}, '0);
        chk({tag, "_vld"},   a_vld, 1'b0);
        chk({tag, "_empty"}, a_empty, 1'b1);
        chk({tag, "_full"},  a_full, 1'b0);
        chk({tag, "_level"}, a_level, '0);
        chk({tag, "_ovf"},   a_ovf, 1'b0);
        chk({tag, "_udf"},   a_udf, 1'b0);
        chk({tag, "_b_qr"},  {b_keep, b_qr, b_vld}, '0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_last = 1'b0; rd_en = 1'b0; clr_err = 1'b0; dw = '0;
        repeat (2) @(negedge clk);
        chk_reset("rst0");
        rst = 1'b0;
        @(negedge clk);

        // Full word, normal and reversed packing
        word4(32'h44332211, 1'b0);
        chk("level_one", a_level, 4'd1);
        rd();
        chk("level_zero", a_level, 4'd0);
        @(negedge clk);
        chk("vld_pulse", a_vld, 1'b0);
        chk("qr_hold", {a_keep, a_qr}, last_a);

        // Partial flush, then a full word starting again from lane 0
        exp_push(36'h3_0000BBAA);
        wr(8'hAA, 1'b0, 1'b0);
        wr(8'hBB, 1'b1, 1'b0);
        word4(32'h04030201, 1'b0);
        chk("level_two", a_level, 4'd2);
        rd();
        rd();

        // wr_last on lane 0
        exp_push(36'h1_0000005A);
        wr(8'h5A, 1'b1, 1'b0);
        rd();
        @(negedge clk);

        // Fill to full across the pointer wrap
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] b;
            b = 8'(8'h80 + 4*i);
            word4({b + 8'd3, b + 8'd2, b + 8'd1, b}, 1'b0);
        end
        chk("full_flag", a_full, 1'b1);
        chk("full_level", a_level, 4'd8);
        chk("full_not_empty", a_empty, 1'b0);
        wr(8'hE1, 1'b0, 1'b0);
        chk("ovf_set", a_ovf, 1'b1);
        chk("ovf_level", a_level, 4'd8);
        // Pop and write together at full: the write is still dropped
        wr(8'hE2, 1'b1, 1'b1);
        chk("full_pop_level", a_level, 4'd7);
        chk("full_pop_notfull", a_full, 1'b0);
        repeat (DEPTH - 1) rd();
        chk("drain_empty", a_empty, 1'b1);
        chk("drain_level", a_level, 4'd0);
        chk("ovf_sticky", a_ovf, 1'b1);

        rd();
        chk("udf_vld", a_vld, 1'b0);
        chk("udf_set", a_udf, 1'b1);
        chk("udf_set_b", b_udf, 1'b1);
        clr_err = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        clr_err = 1'b0; rd_en = 1'b0;
        chk("udf_set_priority", a_udf, 1'b1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("clr_ovf", a_ovf, 1'b0);
        chk("clr_udf", a_udf, 1'b0);

        // Dropped writes must not have moved the lane counter
        word4(32'h64636261, 1'b0);
        rd();

        // Simultaneous push and pop at level 3
        word4(32'h13121110, 1'b0);
        word4(32'h17161514, 1'b0);
        word4(32'h1B1A1918, 1'b0);
        chk("sim_pre_level", a_level, 4'd3);
        word4(32'h1F1E1D1C, 1'b1);
        chk("sim_level", a_level, 4'd3);
        repeat (3) rd();
        chk("sim_drain", a_level, 4'd0);

        // Reset mid-frame with stored words and a half-packed word
        for (int i = 0; i < 5; i++) word4(32'h0 + 32'(i), 1'b0);
        chk("pre_rst_level", a_level, 4'd5);
        wr(8'hD1, 1'b0, 1'b0);
        wr(8'hD2, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk_reset("rst_mid");
        qa.delete();
        qb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        word4(32'hC4C3C2C1, 1'b0);
        rd();
        repeat (2) @(negedge clk);

        chk("qa_drained", 36'(qa.size()), '0);
        chk("qb_drained", 36'(qb.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
